// File: rtl/ctl_frame_pkg.sv
// rtl/ctl_frame_pkg.sv - status frame constants, flag layout and FSM encoding
// Shared with the Xilinx-side receiver, so field positions here are part of the link format.
package ctl_frame_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned FRAME_LEN     = 6;

  localparam int unsigned FLG_ACK_ERR   = 0;
  localparam int unsigned FLG_OVERRUN   = 1;
  localparam int unsigned FLG_STALE     = 2;
  localparam int unsigned FLG_W         = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    HOLD,
    DRAIN
  } frame_state_e;

  // Byte order on the wire: sync, seq, port0, port1, flags, checksum.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]       idx,
    input logic [7:0]       sync_b,
    input logic [7:0]       seq,
    input logic [7:0]       p0,
    input logic [7:0]       p1,
    input logic [FLG_W-1:0] flags,
    input logic [7:0]       chk
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync_b;
      3'd1:    b = seq;
      3'd2:    b = p0;
      3'd3:    b = p1;
      3'd4:    b = {{(8-FLG_W){1'b0}}, flags};
      default: b = chk;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ctl_status_framer.sv
// rtl/ctl_status_framer.sv - packs expander port snapshots into 6-byte status frames for uart_tx
// Holds one pending sample, sends heartbeat re-sends when the poller goes quiet.
module ctl_status_framer
  import ctl_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE        = SYNC_BYTE_DEF,
  parameter int unsigned HEARTBEAT_CYCLES = 4800000,
  parameter int unsigned CNT_W            = 23
) (
  input  logic       clk48,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample_port0,
  input  logic [7:0] sample_port1,
  input  logic       i2c_ack_error,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_send,
  output logic       frame_busy
);

  localparam logic [2:0]       LAST_IDX = 3'(FRAME_LEN - 1);
  localparam bit               HB_EN    = (HEARTBEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] HB_LAST  = HB_EN ? CNT_W'(HEARTBEAT_CYCLES - 1) : '0;

  frame_state_e     state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       seq_q, seq_d;
  logic             pending_q, pending_d;
  logic [FLG_W-1:0] flags_q, flags_d;
  logic [7:0]       last_p0_q, last_p0_d;
  logic [7:0]       last_p1_q, last_p1_d;
  logic [7:0]       fr_seq_q, fr_seq_d;
  logic [7:0]       fr_p0_q, fr_p0_d;
  logic [7:0]       fr_p1_q, fr_p1_d;
  logic [FLG_W-1:0] fr_flags_q, fr_flags_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_send_q, tx_send_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hb_cnt_q, hb_cnt_d;

  logic [7:0]       cur_byte;
  logic             hb_fire;

  assign cur_byte = frame_byte(idx_q, SYNC_BYTE, fr_seq_q, fr_p0_q, fr_p1_q, fr_flags_q, chk_q);

  // A real sample in the same cycle always beats a heartbeat re-send.
  assign hb_fire = HB_EN && (state_q == IDLE) && !pending_q && !sample_valid &&
                   (hb_cnt_q == HB_LAST);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    seq_d      = seq_q;
    pending_d  = pending_q;
    flags_d    = flags_q;
    last_p0_d  = last_p0_q;
    last_p1_d  = last_p1_q;
    fr_seq_d   = fr_seq_q;
    fr_p0_d    = fr_p0_q;
    fr_p1_d    = fr_p1_q;
    fr_flags_d = fr_flags_q;
    tx_data_d  = tx_data_q;
    tx_send_d  = tx_send_q;
    busy_d     = busy_q;
    hb_cnt_d   = hb_cnt_q;

    if (sample_valid) begin
      last_p0_d = sample_port0;
      last_p1_d = sample_port1;
      pending_d = 1'b1;
      if (pending_q && (state_q != LOAD)) begin
        flags_d[FLG_OVERRUN] = 1'b1;
      end
    end
    if (i2c_ack_error) begin
      flags_d[FLG_ACK_ERR] = 1'b1;
    end
    if (hb_fire) begin
      pending_d          = 1'b1;
      flags_d[FLG_STALE] = 1'b1;
    end

    // Counter only advances while idle, so the heartbeat period excludes frame time.
    if (!HB_EN || sample_valid || (state_q == LOAD)) begin
      hb_cnt_d = '0;
    end else if ((state_q == IDLE) && (hb_cnt_q != HB_LAST)) begin
      hb_cnt_d = hb_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (pending_q || sample_valid || hb_fire) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        fr_seq_d   = seq_q;
        fr_p0_d    = last_p0_q;
        fr_p1_d    = last_p1_q;
        fr_flags_d = flags_q;
        pending_d  = sample_valid;
        flags_d    = '0;
        flags_d[FLG_ACK_ERR] = i2c_ack_error;
        idx_d      = 3'd0;
        busy_d     = 1'b1;
        // Issue the sync byte straight from LOAD when the UART is idle.
        if (tx_ready) begin
          tx_data_d = SYNC_BYTE;
          tx_send_d = 1'b1;
          chk_d     = SYNC_BYTE;
          state_d   = HOLD;
        end else begin
          chk_d   = 8'h00;
          state_d = ARM;
        end
      end
      ARM: begin
        if (tx_ready) begin
          tx_data_d = cur_byte;
          tx_send_d = 1'b1;
          chk_d     = chk_q ^ cur_byte;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (!tx_ready) begin
          tx_send_d = 1'b0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            seq_d   = seq_q + 8'd1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ARM;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      chk_q      <= 8'h00;
      seq_q      <= 8'h00;
      pending_q  <= 1'b0;
      flags_q    <= '0;
      last_p0_q  <= 8'h00;
      last_p1_q  <= 8'h00;
      fr_seq_q   <= 8'h00;
      fr_p0_q    <= 8'h00;
      fr_p1_q    <= 8'h00;
      fr_flags_q <= '0;
      tx_data_q  <= 8'h00;
      tx_send_q  <= 1'b0;
      busy_q     <= 1'b0;
      hb_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      seq_q      <= seq_d;
      pending_q  <= pending_d;
      flags_q    <= flags_d;
      last_p0_q  <= last_p0_d;
      last_p1_q  <= last_p1_d;
      fr_seq_q   <= fr_seq_d;
      fr_p0_q    <= fr_p0_d;
      fr_p1_q    <= fr_p1_d;
      fr_flags_q <= fr_flags_d;
      tx_data_q  <= tx_data_d;
      tx_send_q  <= tx_send_d;
      busy_q     <= busy_d;
      hb_cnt_q   <= hb_cnt_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_send    = tx_send_q;
  assign frame_busy = busy_q;

endmodule
